// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory, redirect source and decode.
// The master modport is the sequencer's view. The slave modport is the environment's view.
interface fetch_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic        misalign_trap;
  logic [31:0] misalign_addr;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pcplus4,
           misalign_trap, misalign_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
           redirect_target, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pcplus4,
           misalign_trap, misalign_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
           redirect_target, if_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// It holds each fetched word until decode takes it, and it handles redirects and misaligned-target traps.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP, S_TRAP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_vld;
  logic        drop_to_trap;
  logic        if_vld_q;
  logic [31:0] instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc4_q;
  logic        trap_q;
  logic [31:0] trap_addr_q;

  logic        accepted;
  logic        outstanding;
  logic        aligned;

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // A response is still owed after this edge if a request is accepted now,
  // or if an earlier request has not been answered in this cycle.
  always_comb begin
    accepted    = (state == S_REQ) && req_vld && bus.imem_req_ready;
    outstanding = accepted ||
                  (((state == S_WAIT) || (state == S_DROP)) && !bus.imem_resp_valid);
    aligned     = (bus.redirect_target[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      req_vld      <= 1'b0;
      drop_to_trap <= 1'b0;
      if_vld_q     <= 1'b0;
      instr_q      <= NOP_INSTR;
      if_pc_q      <= RESET_PC;
      if_pc4_q     <= pc_inc(RESET_PC);
      trap_q       <= 1'b0;
      trap_addr_q  <= 32'h0;
    end else begin
      trap_q <= 1'b0;
      if (bus.redirect_valid) begin
        if_vld_q <= 1'b0;
        instr_q  <= NOP_INSTR;
        req_vld  <= 1'b0;
        if (aligned) begin
          pc           <= bus.redirect_target;
          drop_to_trap <= 1'b0;
          if (outstanding) begin
            state <= S_DROP;
          end else begin
            state   <= S_REQ;
            req_vld <= 1'b1;
          end
        end else begin
          trap_q      <= 1'b1;
          trap_addr_q <= bus.redirect_target;
          if (outstanding) begin
            state        <= S_DROP;
            drop_to_trap <= 1'b1;
          end else begin
            state <= S_TRAP;
          end
        end
      end else begin
        case (state)
          // req_vld is low only in the bubble cycle right after reset.
          S_REQ: begin
            if (!req_vld) begin
              req_vld <= 1'b1;
            end else if (bus.imem_req_ready) begin
              req_vld <= 1'b0;
              state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.imem_resp_valid) begin
              instr_q  <= bus.imem_resp_data;
              if_pc_q  <= pc;
              if_pc4_q <= pc_inc(pc);
              if_vld_q <= 1'b1;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (bus.if_ready) begin
              if_vld_q <= 1'b0;
              instr_q  <= NOP_INSTR;
              pc       <= pc_inc(pc);
              req_vld  <= 1'b1;
              state    <= S_REQ;
            end
          end
          S_DROP: begin
            if (bus.imem_resp_valid) begin
              if (drop_to_trap) begin
                drop_to_trap <= 1'b0;
                state        <= S_TRAP;
              end else begin
                req_vld <= 1'b1;
                state   <= S_REQ;
              end
            end
          end
          S_TRAP:  state <= S_TRAP;
          default: state <= S_REQ;
        endcase
      end
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = if_vld_q;
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_pcplus4     = if_pc4_q;
  assign bus.misalign_trap  = trap_q;
  assign bus.misalign_addr  = trap_addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. It uses directed vectors, corner-case sequences,
// and random traffic, and it checks them against a transaction-level model.
module tb_fetch_sequencer;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RP0 = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fetch_sequencer_if bus();
  fetch_sequencer_if bus2();

  fetch_sequencer #(.RESET_PC(RP0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  // The second instance runs against an ideal memory and decode, with no redirects.
  assign bus2.imem_req_ready  = 1'b1;
  assign bus2.imem_resp_valid = 1'b1;
  assign bus2.imem_resp_data  = 32'h0000_0093;
  assign bus2.redirect_valid  = 1'b0;
  assign bus2.redirect_target = 32'h0;
  assign bus2.if_ready        = 1'b1;

  always #5 clk = ~clk;

  // Transaction-level model: a fetch is pending issue, awaited, held, or being discarded.
  logic [31:0] m_pc, m_instr, m_ipc, m_taddr;
  bit m_req, m_pending, m_wait, m_discard, m_held, m_halt_pending, m_trap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc, owed;
    if (rst) begin
      m_pc = RP0; m_req = 0; m_pending = 1; m_wait = 0; m_discard = 0;
      m_held = 0; m_instr = NOP; m_ipc = RP0; m_halt_pending = 0;
      m_trap = 0; m_taddr = 32'h0;
      return;
    end
    acc  = m_pending && m_req && bus.imem_req_ready;
    owed = acc || ((m_wait || m_discard) && !bus.imem_resp_valid);
    m_trap = 0;
    if (bus.redirect_valid) begin
      m_held = 0; m_wait = 0; m_discard = owed; m_req = 0; m_pending = 0;
      if (bus.redirect_target[1:0] == 2'b00) begin
        m_pc = bus.redirect_target;
        m_halt_pending = 0;
        if (!owed) begin m_pending = 1; m_req = 1; end
      end else begin
        m_trap = 1; m_taddr = bus.redirect_target;
        m_halt_pending = owed;
      end
    end else if (m_pending) begin
      if (acc) begin m_pending = 0; m_req = 0; m_wait = 1; end
      else m_req = 1;
    end else if (m_wait) begin
      if (bus.imem_resp_valid) begin
        m_wait = 0; m_held = 1; m_instr = bus.imem_resp_data; m_ipc = m_pc;
      end
    end else if (m_held) begin
      if (bus.if_ready) begin m_held = 0; m_pc = m_pc + 32'd4; m_pending = 1; m_req = 1; end
    end else if (m_discard) begin
      if (bus.imem_resp_valid) begin
        m_discard = 0;
        if (m_halt_pending) m_halt_pending = 0;
        else begin m_pending = 1; m_req = 1; end
      end
    end
  endtask

  task automatic compare_model();
    chk1("m_req_valid", bus.imem_req_valid, m_req);
    if (m_req) chk("m_imem_addr", bus.imem_addr, m_pc);
    chk1("m_if_valid", bus.if_valid, m_held);
    chk("m_if_instr", bus.if_instr, m_held ? m_instr : NOP);
    if (m_held) begin
      chk("m_if_pc", bus.if_pc, m_ipc);
      chk("m_if_pcplus4", bus.if_pcplus4, m_ipc + 32'd4);
    end
    chk1("m_trap", bus.misalign_trap, m_trap);
    if (m_trap) chk("m_trap_addr", bus.misalign_addr, m_taddr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.if_valid && n < budget) begin tick(); n++; end
    chk1(name, bus.if_valid, 1'b1);
  endtask

  typedef struct {
    logic        rdy, resp, ifrdy;
    logic [31:0] data;
    logic        ereq, ev, cpc;
    logic [31:0] eaddr, einstr, epc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] d, input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] einstr,
                              input logic cpc, input logic [31:0] epc);
    vec_t v;
    v.rdy = 1'b1; v.resp = 1'b1; v.ifrdy = 1'b1; v.data = d;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.einstr = einstr; v.cpc = cpc; v.epc = epc;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [31:0] t;
    tbl[0] = mk(32'h1000_0000, 0, 32'h0, 0, NOP,           1, 32'h0);
    tbl[1] = mk(32'h1000_0001, 1, 32'h0, 0, NOP,           0, 32'h0);
    tbl[2] = mk(32'h1000_0002, 0, 32'h0, 0, NOP,           0, 32'h0);
    tbl[3] = mk(32'h1000_0003, 0, 32'h0, 1, 32'h1000_0002, 1, 32'h0);
    tbl[4] = mk(32'h1000_0004, 1, 32'h4, 0, NOP,           0, 32'h0);
    tbl[5] = mk(32'h1000_0005, 0, 32'h0, 0, NOP,           0, 32'h0);
    tbl[6] = mk(32'h1000_0006, 0, 32'h0, 1, 32'h1000_0005, 1, 32'h4);
    tbl[7] = mk(32'h1000_0007, 1, 32'h8, 0, NOP,           0, 32'h0);

    rst = 1'b1;
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
    bus.redirect_valid = 0; bus.redirect_target = 0; bus.if_ready = 0;
    tick(); tick();
    chk("rst_trap_addr", bus.misalign_addr, 32'h0);
    chk("rst2_pcplus4", bus2.if_pcplus4, 32'h0);
    chk("rst2_if_pc", bus2.if_pc, 32'hFFFF_FFFC);

    // Zero-wait streaming: one fetch every three cycles
    for (int i = 0; i < 8; i++) begin
      chk1("tbl_req_valid", bus.imem_req_valid, tbl[i].ereq);
      if (tbl[i].ereq) chk("tbl_addr", bus.imem_addr, tbl[i].eaddr);
      chk1("tbl_if_valid", bus.if_valid, tbl[i].ev);
      chk("tbl_if_instr", bus.if_instr, tbl[i].einstr);
      if (tbl[i].cpc) begin
        chk("tbl_if_pc", bus.if_pc, tbl[i].epc);
        chk("tbl_if_pcplus4", bus.if_pcplus4, tbl[i].epc + 32'd4);
      end
      if (i == 1) chk("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
      if (i == 3) chk("wrap_pcplus4", bus2.if_pcplus4, 32'h0);
      if (i == 4) chk("wrap_second_addr", bus2.imem_addr, 32'h0);
      rst = 1'b0;
      bus.imem_req_ready = tbl[i].rdy; bus.imem_resp_valid = tbl[i].resp;
      bus.imem_resp_data = tbl[i].data; bus.if_ready = tbl[i].ifrdy;
      tick();
    end

    // Decode stall: the held word stays put and no request is issued
    bus.if_ready = 0; bus.imem_resp_data = 32'hABCD_0001;
    wait_valid("stall_reach_hold", 10);
    for (int k = 0; k < 5; k++) begin
      bus.imem_resp_data = $urandom;
      tick();
      chk1("stall_if_valid", bus.if_valid, 1'b1);
      chk("stall_if_instr", bus.if_instr, 32'hABCD_0001);
      chk("stall_if_pc", bus.if_pc, 32'h8);
      chk1("stall_no_req", bus.imem_req_valid, 1'b0);
    end
    bus.if_ready = 1; tick();
    chk("stall_next_addr", bus.imem_addr, 32'hC);

    // Redirect during a wait, with the stale response arriving two cycles later
    bus.imem_resp_valid = 0; tick();
    bus.redirect_valid = 1; bus.redirect_target = 32'h100; bus.imem_req_ready = 0;
    tick();
    bus.redirect_valid = 0;
    chk1("redir_if_valid", bus.if_valid, 1'b0);
    tick();
    chk1("redir_drop_no_req", bus.imem_req_valid, 1'b0);
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hDEAD_BEEF; tick();
    chk1("redir_req_valid", bus.imem_req_valid, 1'b1);
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_no_stale", bus.if_instr, NOP);
    bus.imem_resp_valid = 0; bus.imem_req_ready = 1; tick();
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h0010_0113; tick();
    chk("redir_fetched_pc", bus.if_pc, 32'h100);
    chk("redir_fetched_instr", bus.if_instr, 32'h0010_0113);

    // Misaligned redirect halts fetch until an aligned redirect arrives
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; tick();
    bus.redirect_valid = 1; bus.redirect_target = 32'h102; tick();
    chk1("trap_pulse", bus.misalign_trap, 1'b1);
    chk("trap_addr", bus.misalign_addr, 32'h102);
    chk1("trap_no_req", bus.imem_req_valid, 1'b0);
    bus.redirect_valid = 0; bus.imem_req_ready = 1; tick();
    chk1("trap_pulse_end", bus.misalign_trap, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("trap_halted", bus.imem_req_valid, 1'b0);
    end
    bus.redirect_valid = 1; bus.redirect_target = 32'h200; tick();
    bus.redirect_valid = 0;
    chk1("resume_req", bus.imem_req_valid, 1'b1);
    chk("resume_addr", bus.imem_addr, 32'h200);

    // Reset while a response is outstanding; the late response must be ignored
    tick();
    rst = 1; tick();
    rst = 0; bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hBAD0_BAD0; tick();
    chk1("rstw_if_valid", bus.if_valid, 1'b0);
    chk1("rstw_req", bus.imem_req_valid, 1'b1);
    chk("rstw_addr", bus.imem_addr, RP0);
    bus.imem_resp_valid = 0; tick();
    chk1("rstw_if_valid2", bus.if_valid, 1'b0);
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h0000_0093; tick();
    chk("rstw_instr", bus.if_instr, 32'h0000_0093);
    chk("rstw_pc", bus.if_pc, RP0);

    // Random traffic checked against the model every cycle
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom_range(150) == 0);
      bus.imem_req_ready  = ($urandom_range(3) != 0);
      bus.imem_resp_valid = (m_wait || m_discard) && ($urandom_range(2) != 0);
      bus.imem_resp_data  = $urandom;
      bus.if_ready        = ($urandom_range(2) != 0);
      bus.redirect_valid  = ($urandom_range(11) == 0);
      t = $urandom;
      if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3));
      else t[1:0] = 2'b00;
      if ($urandom_range(15) == 0) t = 32'hFFFF_FFFC;
      bus.redirect_target = t;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
